jtkicker_psgq: RTL and testbench
================================

JTKICKER_PSGQ -- requirements
Module: jtkicker_psgq

Parameters
REQ-001 SHALL have parameter NCH, default 2, number of PSG channels, range 1..4.
REQ-002 SHALL have parameter AW, default 3, per-channel FIFO address width; depth DEPTH = 2^AW.
REQ-003 SHALL have parameter FULL_MODE, default 0; 0 = drop write when full, 1 = stall CPU when full.
REQ-004 SHALL have parameter TOUT, default 16, number of cen pulses STROBE waits for ready low.

Interface
REQ-005 SHALL have: clk  input  1  system clock, 24 MHz; the only clock.
REQ-006 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have: cen  input  1  PSG clock enable, 3 MHz, one clk wide.
REQ-008 SHALL have: wr  input  1  one-clk write strobe from CPU decoder.
REQ-009 SHALL have: ch  input  2  target channel; values >= NCH are ignored.
REQ-010 SHALL have: din  input  8  byte to queue.
REQ-011 SHALL have: cpu_wait  output  1  combinational stall request; FULL_MODE=1 only.
REQ-012 SHALL have: full, empty  output  NCH each  registered FIFO flags per channel.
REQ-013 SHALL have: ovf  output  NCH  sticky overflow flag per channel.
REQ-014 SHALL have: ovf_clr  input  1  clears all ovf bits.
REQ-015 SHALL have: busy  output  NCH  high when channel FSM is not IDLE.
REQ-016 SHALL have: psg_cs_n, psg_wr_n  output  NCH each  PSG strobes.
REQ-017 SHALL have: psg_din  output  8*NCH  PSG data, channel k on bits [8k+7:8k].
REQ-018 SHALL have: psg_ready  input  NCH  PSG ready, high = idle.

Function
REQ-019 SHALL accept a write when wr=1, ch<NCH and full[ch]=0 (registered count, not counting a same-cycle pop).
REQ-020 SHALL, on write to a full FIFO, leave FIFO unchanged and set ovf[ch]; FULL_MODE=1 also asserts cpu_wait = wr & full[ch] in that cycle.
REQ-021 SHALL keep FULL_MODE=0 cpu_wait tied to 0.
REQ-022 SHALL give ovf_clr priority over a simultaneous overflow set (result 0).
REQ-023 SHALL keep occupancy unchanged when push and pop hit the same channel in one cycle; pointers wrap modulo DEPTH.
REQ-024 SHALL run one FSM per channel, states IDLE, STROBE, BUSY.
REQ-025 IDLE: if empty=0, pop head into psg_din register, go STROBE next edge; psg_din changes only here.
REQ-026 STROBE: psg_cs_n=0, psg_wr_n=0; on a cen cycle with psg_ready=0 go BUSY; after TOUT cen cycles without it go BUSY anyway.
REQ-027 BUSY: psg_cs_n=1, psg_wr_n=1; on a cen cycle with psg_ready=1 go IDLE.
REQ-028 SHALL drive strobes from registered state (glitch-free); channels run independently.
REQ-029 SHALL assert psg_cs_n low exactly 2 clk after an accepted write to an empty, IDLE channel.
REQ-030 SHALL deliver bytes per channel in write order with none lost except rejected overflow writes.

Reset
REQ-031 SHALL, while rst=1 at a clk edge, clear FIFOs (empty=all 1, full=0), ovf=0, FSMs to IDLE, psg_cs_n=psg_wr_n=all 1, psg_din=0, busy=0.
REQ-032 SHALL abort a STROBE/BUSY in progress at reset, releasing strobes on the next edge; cpu_wait=0 during reset.

Verification
REQ-033 Write 0x9F to ch0, idle and empty -> psg_cs_n[0]=0 two clk later, psg_din[7:0]=0x9F; ready low on cen -> BUSY; ready high -> IDLE, empty[0]=1.
REQ-034 AW=3, PSG held busy, 9 writes 0x01..0x09 to ch1 in FULL_MODE=0 -> full[1]=1 after 8th, 0x09 dropped, ovf[1]=1; output order 0x01..0x08.
REQ-035 FULL_MODE=1, ch0 full, wr to ch0 -> cpu_wait=1 same cycle; after one pop, retried write accepted, cpu_wait=0.
REQ-036 Interleaved writes to ch0 (0xA0..0xA3) and ch1 (0xB0..0xB3) with different ready timings -> each port emits its own sequence in order, independently.
REQ-037 psg_ready stuck high -> STROBE exits after 16 cen pulses; rst asserted during BUSY -> strobes high, FIFOs empty next edge.

Source files
------------

// File: rtl/jtkicker_psgq.sv
// Per-channel write queue between the CPU bus and slow PSG chips.
// Each channel owns a small FIFO plus an IDLE/STROBE/BUSY handshake FSM.
module jtkicker_psgq #(
    parameter int NCH       = 2,
    parameter int AW        = 3,
    parameter int FULL_MODE = 0,
    parameter int TOUT      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             wr,
    input  logic [1:0]       ch,
    input  logic [7:0]       din,
    output logic             cpu_wait,
    output logic [NCH-1:0]   full,
    output logic [NCH-1:0]   empty,
    output logic [NCH-1:0]   ovf,
    input  logic             ovf_clr,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   psg_cs_n,
    output logic [NCH-1:0]   psg_wr_n,
    output logic [8*NCH-1:0] psg_din,
    input  logic [NCH-1:0]   psg_ready
);
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(TOUT + 1);

    typedef enum logic [1:0] {IDLE, STROBE, BUSY} state_t;

    logic       ch_ok;
    logic [3:0] full_ext;

    assign ch_ok    = int'(ch) < NCH;
    assign full_ext = 4'(full);
    // Stall is purely combinational so the CPU sees it in the very cycle it writes.
    assign cpu_wait = (FULL_MODE != 0) && wr && ch_ok && full_ext[ch] && !rst;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [7:0]    mem [DEPTH];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [AW:0]   count_reg, count_next;
            logic          full_reg, empty_reg, ovf_reg, cs_n_reg;
            logic [TW-1:0] tcnt_reg;
            logic [7:0]    dout_reg;
            state_t        state_reg;
            logic          sel, push, pop;

            assign sel  = wr && ch_ok && (ch == 2'(gi));
            assign push = sel && !full_reg;
            assign pop  = (state_reg == IDLE) && !empty_reg;

            always_comb begin
                count_next = count_reg;
                if (push && !pop)
                    count_next = count_reg + 1'b1;
                else if (pop && !push)
                    count_next = count_reg - 1'b1;
            end

            always_ff @(posedge clk) begin
                if (push)
                    mem[wr_ptr_reg] <= din;
            end

            // Registered RAM read doubles as the PSG data latch.
            always_ff @(posedge clk) begin
                if (rst)
                    dout_reg <= 8'd0;
                else if (pop)
                    dout_reg <= mem[rd_ptr_reg];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    full_reg   <= 1'b0;
                    empty_reg  <= 1'b1;
                    ovf_reg    <= 1'b0;
                    state_reg  <= IDLE;
                    tcnt_reg   <= '0;
                    cs_n_reg   <= 1'b1;
                end else begin
                    if (push)
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop)
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_next;
                    full_reg  <= count_next == (AW+1)'(DEPTH);
                    empty_reg <= count_next == '0;
                    if (ovf_clr)
                        ovf_reg <= 1'b0;
                    else if (sel && full_reg)
                        ovf_reg <= 1'b1;

                    case (state_reg)
                        IDLE: begin
                            if (!empty_reg) begin
                                state_reg <= STROBE;
                                cs_n_reg  <= 1'b0;
                                tcnt_reg  <= '0;
                            end
                        end
                        STROBE: begin
                            // A PSG that never drops ready must not hang the queue.
                            if (cen) begin
                                if (!psg_ready[gi] || tcnt_reg == TW'(TOUT - 1)) begin
                                    state_reg <= BUSY;
                                    cs_n_reg  <= 1'b1;
                                end else begin
                                    tcnt_reg <= tcnt_reg + 1'b1;
                                end
                            end
                        end
                        BUSY: begin
                            if (cen && psg_ready[gi])
                                state_reg <= IDLE;
                        end
                        default: begin
                            state_reg <= IDLE;
                            cs_n_reg  <= 1'b1;
                        end
                    endcase
                end
            end

            assign full[gi]            = full_reg;
            assign empty[gi]           = empty_reg;
            assign ovf[gi]             = ovf_reg;
            assign busy[gi]            = state_reg != IDLE;
            assign psg_cs_n[gi]        = cs_n_reg;
            assign psg_wr_n[gi]        = cs_n_reg;
            assign psg_din[8*gi +: 8]  = dout_reg;
        end
    endgenerate
endmodule

// File: tb/tb_jtkicker_psgq.sv
// Scoreboard bench for jtkicker_psgq: drop-mode instance with a PSG responder
// model, plus a stall-mode instance driven directly.
module tb_jtkicker_psgq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        wr = 1'b0, ovf_clr = 1'b0;
    logic [1:0]  ch = 2'd0;
    logic [7:0]  din = 8'd0;
    logic [1:0]  psg_ready = 2'b11;
    logic        cpu_wait;
    logic [1:0]  full, empty, ovf, busy, psg_cs_n, psg_wr_n;
    logic [15:0] psg_din;

    logic        wr2 = 1'b0;
    logic [7:0]  din2 = 8'd0;
    logic [1:0]  ready2 = 2'b00;
    logic        cpu_wait2;
    logic [1:0]  full2, empty2, ovf2, busy2, cs_n2, wr_n2;
    logic [15:0] psg_din2;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    logic [1:0] hold = 2'b00, stuck = 2'b00, prev_cs = 2'b11;
    int         delay[2] = '{2, 2};
    int         bcnt[2]  = '{0, 0};
    int         cen_div  = 0;
    logic [7:0] mon_got, mon_exp;
    bit         mon_have;

    jtkicker_psgq #(.NCH(2), .AW(3), .FULL_MODE(0), .TOUT(16)) dut (
        .clk(clk), .rst(rst), .cen(cen), .wr(wr), .ch(ch), .din(din),
        .cpu_wait(cpu_wait), .full(full), .empty(empty), .ovf(ovf),
        .ovf_clr(ovf_clr), .busy(busy), .psg_cs_n(psg_cs_n),
        .psg_wr_n(psg_wr_n), .psg_din(psg_din), .psg_ready(psg_ready)
    );

    jtkicker_psgq #(.NCH(2), .AW(3), .FULL_MODE(1), .TOUT(16)) dut_s (
        .clk(clk), .rst(rst), .cen(cen), .wr(wr2), .ch(2'd0), .din(din2),
        .cpu_wait(cpu_wait2), .full(full2), .empty(empty2), .ovf(ovf2),
        .ovf_clr(1'b0), .busy(busy2), .psg_cs_n(cs_n2),
        .psg_wr_n(wr_n2), .psg_din(psg_din2), .psg_ready(ready2)
    );

    always #5 clk = ~clk;

    // cen every 8 clk, plus a PSG model that drops ready while strobed.
    always @(posedge clk) begin
        #1;
        cen_div = (cen_div + 1) % 8;
        cen = (cen_div == 0);
        for (int k = 0; k < 2; k++) begin
            if (hold[k]) psg_ready[k] = 1'b0;
            else if (stuck[k]) psg_ready[k] = 1'b1;
            else if (!psg_cs_n[k]) begin
                psg_ready[k] = 1'b0;
                bcnt[k] = 0;
            end else if (!psg_ready[k] && cen) begin
                bcnt[k]++;
                if (bcnt[k] >= delay[k]) psg_ready[k] = 1'b1;
            end
        end
    end

    // Scoreboard: each falling psg_cs_n consumes one expected byte.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (prev_cs[k] && !psg_cs_n[k]) begin
                mon_got = psg_din[8*k +: 8];
                mon_have = 0;
                if (k == 0 && exp_q0.size() > 0) begin mon_exp = exp_q0.pop_front(); mon_have = 1; end
                if (k == 1 && exp_q1.size() > 0) begin mon_exp = exp_q1.pop_front(); mon_have = 1; end
                checks++;
                if (!mon_have) begin
                    errors++;
                    $display("FAIL unexpected_byte ch%0d got=%02h expected=none", k, mon_got);
                end else if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL byte_order ch%0d got=%02h expected=%02h", k, mon_got, mon_exp);
                end else
                    $display("byte ch%0d got=%02h ok", k, mon_got);
            end
        end
        prev_cs = psg_cs_n;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr_byte(input logic [1:0] c, input logic [7:0] d);
        ch = c; din = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while ((busy[k] || !empty[k]) && n < budget) begin tick(); n++; end
        checks++;
        if (n >= budget) begin errors++; $display("FAIL idle_timeout ch%0d got=busy expected=idle", k); end
    endtask

    task automatic wait_busy_state(input int k, input int budget);
        int n = 0;
        while (!(busy[k] && psg_cs_n[k]) && n < budget) begin tick(); n++; end
        checks++;
        if (n >= budget) begin errors++; $display("FAIL busy_timeout ch%0d got=not_busy expected=BUSY", k); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks += 8;
        if (empty !== 2'b11)     begin errors++; $display("FAIL rst_empty got=%b expected=11", empty); end
        if (full !== 2'b00)      begin errors++; $display("FAIL rst_full got=%b expected=00", full); end
        if (ovf !== 2'b00)       begin errors++; $display("FAIL rst_ovf got=%b expected=00", ovf); end
        if (psg_cs_n !== 2'b11)  begin errors++; $display("FAIL rst_cs_n got=%b expected=11", psg_cs_n); end
        if (psg_wr_n !== 2'b11)  begin errors++; $display("FAIL rst_wr_n got=%b expected=11", psg_wr_n); end
        if (psg_din !== 16'h0)   begin errors++; $display("FAIL rst_din got=%h expected=0000", psg_din); end
        if (busy !== 2'b00)      begin errors++; $display("FAIL rst_busy got=%b expected=00", busy); end
        if (cpu_wait2 !== 1'b0)  begin errors++; $display("FAIL rst_cpu_wait got=%b expected=0", cpu_wait2); end
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_ignore_ch();
        wr_byte(2'd2, 8'h66);
        wr_byte(2'd3, 8'h55);
        tick();
        checks += 2;
        if (empty !== 2'b11) begin errors++; $display("FAIL ignore_ch_empty got=%b expected=11", empty); end
        if (busy !== 2'b00)  begin errors++; $display("FAIL ignore_ch_busy got=%b expected=00", busy); end
        $display("writes to ch2/ch3 ignored");
    endtask

    task automatic test_single();
        exp_q0.push_back(8'h9F);
        wr_byte(2'd0, 8'h9F);
        checks += 2;
        if (psg_cs_n[0] !== 1'b1) begin errors++; $display("FAIL single_cs_early got=%b expected=1", psg_cs_n[0]); end
        if (empty[0] !== 1'b0)    begin errors++; $display("FAIL single_empty got=%b expected=0", empty[0]); end
        tick();
        checks += 3;
        if (psg_cs_n[0] !== 1'b0)      begin errors++; $display("FAIL single_cs_2clk got=%b expected=0", psg_cs_n[0]); end
        if (psg_wr_n[0] !== 1'b0)      begin errors++; $display("FAIL single_wr_n got=%b expected=0", psg_wr_n[0]); end
        if (psg_din[7:0] !== 8'h9F)    begin errors++; $display("FAIL single_din got=%02h expected=9f", psg_din[7:0]); end
        wait_busy_state(0, 100);
        wait_idle(0, 200);
        checks++;
        if (empty[0] !== 1'b1) begin errors++; $display("FAIL single_empty_end got=%b expected=1", empty[0]); end
        $display("single write 9f done");
    endtask

    task automatic test_overflow();
        hold[1] = 1'b1;
        exp_q1.push_back(8'h00);
        wr_byte(2'd1, 8'h00);
        wait_busy_state(1, 100);
        for (int i = 1; i <= 8; i++) begin
            exp_q1.push_back(8'(i));
            wr_byte(2'd1, 8'(i));
        end
        checks += 2;
        if (full[1] !== 1'b1) begin errors++; $display("FAIL ovf_full8 got=%b expected=1", full[1]); end
        if (ovf[1] !== 1'b0)  begin errors++; $display("FAIL ovf_early got=%b expected=0", ovf[1]); end
        ch = 2'd1; din = 8'h09; wr = 1'b1;
        #1;
        checks++;
        if (cpu_wait !== 1'b0) begin errors++; $display("FAIL drop_mode_wait got=%b expected=0", cpu_wait); end
        @(posedge clk); #1;
        wr = 1'b0;
        checks += 2;
        if (ovf[1] !== 1'b1)  begin errors++; $display("FAIL ovf_set got=%b expected=1", ovf[1]); end
        if (full[1] !== 1'b1) begin errors++; $display("FAIL ovf_full9 got=%b expected=1", full[1]); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++;
        if (ovf[1] !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b expected=0", ovf[1]); end
        ch = 2'd1; din = 8'h0A; wr = 1'b1; ovf_clr = 1'b1;
        tick();
        wr = 1'b0; ovf_clr = 1'b0;
        checks++;
        if (ovf[1] !== 1'b0) begin errors++; $display("FAIL ovf_clr_priority got=%b expected=0", ovf[1]); end
        hold[1] = 1'b0;
        wait_idle(1, 3000);
        checks++;
        if (exp_q1.size() != 0) begin errors++; $display("FAIL ovf_drain got=%0d left expected=0", exp_q1.size()); end
        $display("overflow test done");
    endtask

    task automatic test_stall();
        int n = 0;
        ready2 = 2'b00;
        din2 = 8'hC0; wr2 = 1'b1; tick(); wr2 = 1'b0;
        tick(); tick();
        for (int i = 1; i <= 8; i++) begin
            din2 = 8'hC0 + 8'(i); wr2 = 1'b1; tick();
        end
        wr2 = 1'b0;
        checks++;
        if (full2[0] !== 1'b1) begin errors++; $display("FAIL stall_full got=%b expected=1", full2[0]); end
        din2 = 8'hEE; wr2 = 1'b1;
        #1;
        checks++;
        if (cpu_wait2 !== 1'b1) begin errors++; $display("FAIL stall_wait got=%b expected=1", cpu_wait2); end
        ready2[0] = 1'b1;
        while (cpu_wait2 && n < 100) begin tick(); n++; end
        checks++;
        if (cpu_wait2 !== 1'b0) begin errors++; $display("FAIL stall_release got=%b expected=0", cpu_wait2); end
        tick();
        wr2 = 1'b0;
        checks += 2;
        if (full2[0] !== 1'b1) begin errors++; $display("FAIL stall_retry got=%b expected=1", full2[0]); end
        if (ovf2[0] !== 1'b1)  begin errors++; $display("FAIL stall_ovf got=%b expected=1", ovf2[0]); end
        $display("stall test done");
    endtask

    task automatic test_interleave();
        delay[0] = 1; delay[1] = 3;
        for (int i = 0; i < 4; i++) begin
            exp_q0.push_back(8'hA0 + 8'(i));
            wr_byte(2'd0, 8'hA0 + 8'(i));
            exp_q1.push_back(8'hB0 + 8'(i));
            wr_byte(2'd1, 8'hB0 + 8'(i));
        end
        wait_idle(0, 2000);
        wait_idle(1, 2000);
        checks += 2;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL interleave_ch0 got=%0d left expected=0", exp_q0.size()); end
        if (exp_q1.size() != 0) begin errors++; $display("FAIL interleave_ch1 got=%0d left expected=0", exp_q1.size()); end
        $display("interleave test done");
    endtask

    task automatic test_timeout_reset();
        int n = 0, it = 0;
        bit s;
        stuck[0] = 1'b1;
        exp_q0.push_back(8'h5A);
        wr_byte(2'd0, 8'h5A);
        tick();
        while (it < 400) begin
            s = !psg_cs_n[0];
            @(posedge clk);
            if (s && cen) n++;
            #1;
            it++;
            if (psg_cs_n[0]) break;
        end
        checks += 2;
        if (n != 16)         begin errors++; $display("FAIL timeout_cens got=%0d expected=16", n); end
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL timeout_busy got=%b expected=1", busy[0]); end
        wait_idle(0, 200);
        stuck[0] = 1'b0;
        hold[0] = 1'b1;
        exp_q0.push_back(8'h11);
        wr_byte(2'd0, 8'h11);
        wr_byte(2'd0, 8'h22);
        wr_byte(2'd0, 8'h33);
        wait_busy_state(0, 100);
        rst = 1'b1;
        tick();
        checks += 4;
        if (psg_cs_n !== 2'b11) begin errors++; $display("FAIL abort_cs_n got=%b expected=11", psg_cs_n); end
        if (empty !== 2'b11)    begin errors++; $display("FAIL abort_empty got=%b expected=11", empty); end
        if (busy !== 2'b00)     begin errors++; $display("FAIL abort_busy got=%b expected=00", busy); end
        if (cpu_wait2 !== 1'b0) begin errors++; $display("FAIL abort_wait got=%b expected=0", cpu_wait2); end
        rst = 1'b0;
        hold[0] = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        tick();
        $display("timeout and reset abort done");
    endtask

    initial begin
        test_reset();
        test_ignore_ch();
        test_single();
        test_overflow();
        test_stall();
        test_interleave();
        test_timeout_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
